// File: rtl/register_file_arbiter_pkg.sv
// rtl/register_file_arbiter_pkg.sv - shared FSM state type and default widths for the register file arbiter
package register_file_arbiter_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 6;
   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE_WAIT,
      ST_READ_STALL,
      ST_READ_ACCESS,
      ST_ACK
   } arb_state_t;

endpackage

// File: rtl/register_file_arbiter.sv
// rtl/register_file_arbiter.sv - processor/debug sharing of the register file ports
// Processor traffic passes through; one debug access at a time is sequenced in by the FSM.
module register_file_arbiter
   import register_file_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] proc_read_address_1,
   input  logic [ADDR_WIDTH-1:0] proc_read_address_2,
   output logic [DATA_WIDTH-1:0] proc_read_value_1,
   output logic [DATA_WIDTH-1:0] proc_read_value_2,
   input  logic [ADDR_WIDTH-1:0] proc_write_address,
   input  logic [DATA_WIDTH-1:0] proc_write_value,
   input  logic                  proc_write_enable,
   output logic                  stall,
   input  logic                  debug_request,
   input  logic                  debug_write,
   input  logic [ADDR_WIDTH-1:0] debug_address,
   input  logic [DATA_WIDTH-1:0] debug_write_value,
   output logic                  debug_ack,
   output logic [DATA_WIDTH-1:0] debug_read_value,
   output logic [ADDR_WIDTH-1:0] rf_read_address_1,
   output logic [ADDR_WIDTH-1:0] rf_read_address_2,
   input  logic [DATA_WIDTH-1:0] rf_read_value_1,
   input  logic [DATA_WIDTH-1:0] rf_read_value_2,
   output logic [ADDR_WIDTH-1:0] rf_write_address,
   output logic [DATA_WIDTH-1:0] rf_write_value,
   output logic                  rf_write_enable
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   logic [CNT_W-1:0]      r_starve_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_read_value;
   logic                  w_starved;
   logic                  w_bypass;

   assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
   assign w_bypass  = proc_write_enable && (proc_write_address == r_addr);

   // Moore decode only: stall must never see a combinational path from inputs.
   assign stall = (r_state == ST_READ_STALL) || (r_state == ST_READ_ACCESS) ||
                  ((r_state == ST_WRITE_WAIT) && w_starved);
   assign debug_ack         = (r_state == ST_ACK);
   assign debug_read_value  = r_read_value;
   assign proc_read_value_1 = rf_read_value_1;
   assign proc_read_value_2 = rf_read_value_2;
   assign rf_read_address_2 = proc_read_address_2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= '0;
         r_addr       <= '0;
         r_data       <= '0;
         r_read_value <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            ST_IDLE: begin
               if (debug_request) begin
                  r_addr       <= debug_address;
                  r_data       <= debug_write_value;
                  r_starve_cnt <= '0;
               end
            end
            ST_WRITE_WAIT: begin
               if (proc_write_enable && !w_starved) begin
                  r_starve_cnt <= r_starve_cnt + CNT_W'(1);
               end
            end
            ST_READ_ACCESS: r_read_value <= w_bypass ? proc_write_value : rf_read_value_1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state      = r_state;
      rf_read_address_1 = proc_read_address_1;
      rf_write_address  = proc_write_address;
      rf_write_value    = proc_write_value;
      rf_write_enable   = proc_write_enable;
      case (r_state)
         ST_IDLE: begin
            if (debug_request) begin
               w_next_state = debug_write ? ST_WRITE_WAIT : ST_READ_STALL;
            end
         end
         ST_WRITE_WAIT: begin
            if (!proc_write_enable) begin
               rf_write_address = r_addr;
               rf_write_value   = r_data;
               rf_write_enable  = 1'b1;
               w_next_state     = ST_ACK;
            end
         end
         ST_READ_STALL: w_next_state = ST_READ_ACCESS;
         ST_READ_ACCESS: begin
            rf_read_address_1 = r_addr;
            w_next_state      = ST_ACK;
         end
         ST_ACK:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_register_file_arbiter.sv
// tb/tb_register_file_arbiter.sv - self-checking bench for register_file_arbiter
module tb_register_file_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int LIMIT = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] proc_read_address_1, proc_read_address_2, proc_write_address;
   logic [DW-1:0] proc_read_value_1, proc_read_value_2, proc_write_value;
   logic          proc_write_enable, stall;
   logic          debug_request, debug_write, debug_ack;
   logic [AW-1:0] debug_address;
   logic [DW-1:0] debug_write_value, debug_read_value;
   logic [AW-1:0] rf_read_address_1, rf_read_address_2, rf_write_address;
   logic [DW-1:0] rf_read_value_1, rf_read_value_2, rf_write_value;
   logic          rf_write_enable;

   logic [DW-1:0] mem [64];
   logic [DW-1:0] ref_mem [64];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] last_read;

   always #5 clock = ~clock;

   register_file_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .proc_read_address_1(proc_read_address_1), .proc_read_address_2(proc_read_address_2),
      .proc_read_value_1(proc_read_value_1), .proc_read_value_2(proc_read_value_2),
      .proc_write_address(proc_write_address), .proc_write_value(proc_write_value),
      .proc_write_enable(proc_write_enable), .stall(stall),
      .debug_request(debug_request), .debug_write(debug_write),
      .debug_address(debug_address), .debug_write_value(debug_write_value),
      .debug_ack(debug_ack), .debug_read_value(debug_read_value),
      .rf_read_address_1(rf_read_address_1), .rf_read_address_2(rf_read_address_2),
      .rf_read_value_1(rf_read_value_1), .rf_read_value_2(rf_read_value_2),
      .rf_write_address(rf_write_address), .rf_write_value(rf_write_value),
      .rf_write_enable(rf_write_enable)
   );

   // Register file instance seen by the arbiter
   assign rf_read_value_1 = mem[rf_read_address_1];
   assign rf_read_value_2 = mem[rf_read_address_2];
   always @(posedge clock) begin
      if (rf_write_enable) mem[rf_write_address] <= rf_write_value;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference commits the processor write of the closing cycle; the processor always wins its port.
   task automatic cyc();
      if (proc_write_enable) ref_mem[proc_write_address] = proc_write_value;
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic byp, input logic [DW-1:0] bv);
      debug_request = 1'b1; debug_write = 1'b0; debug_address = a;
      proc_write_enable = 1'b0;
      settle(); chk("rd_c0_stall", stall, 0);
      cyc();
      debug_address = ~a;
      settle(); chk("rd_c1_stall", stall, 1); chk("rd_c1_ack", debug_ack, 0);
      cyc();
      if (byp) begin
         proc_write_enable = 1'b1; proc_write_address = a; proc_write_value = bv;
      end
      settle(); chk("rd_c2_stall", stall, 1); chk("rd_c2_addr", rf_read_address_1, a);
      cyc();
      proc_write_enable = 1'b0;
      settle(); chk("rd_c3_ack", debug_ack, 1); chk("rd_c3_stall", stall, 0);
      chk("rd_value", debug_read_value, ref_mem[a]);
      last_read = ref_mem[a];
      debug_request = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      debug_request = 0; debug_write = 0; debug_address = '0; debug_write_value = '0;
      proc_read_address_1 = 6'd1; proc_read_address_2 = 6'd2;
      proc_write_address = 6'd11; proc_write_value = 32'h55; proc_write_enable = 1'b1;
      last_read = '0;
      #3;
      chk("rst_stall", stall, 0);
      chk("rst_ack", debug_ack, 0);
      chk("rst_rdval", debug_read_value, 0);
      chk("rst_we", rf_write_enable, 1);
      chk("rst_wa", rf_write_address, 11);
      proc_write_enable = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < 64; i++) begin
         proc_write_enable = 1'b1; proc_write_address = AW'(i); proc_write_value = $urandom;
         cyc();
      end
      proc_write_enable = 1'b0;

      // Pass-through
      proc_read_address_1 = 6'd3; proc_read_address_2 = 6'd4;
      proc_write_address = 6'd5; proc_write_value = 32'h1234; proc_write_enable = 1'b1;
      settle();
      chk("pt_ra1", rf_read_address_1, 3); chk("pt_ra2", rf_read_address_2, 4);
      chk("pt_rv1", proc_read_value_1, ref_mem[3]); chk("pt_rv2", proc_read_value_2, ref_mem[4]);
      chk("pt_wa", rf_write_address, 5); chk("pt_wv", rf_write_value, 32'h1234);
      chk("pt_we", rf_write_enable, 1); chk("pt_stall", stall, 0);
      cyc();
      proc_write_enable = 1'b0;

      // Uncontended write
      debug_request = 1; debug_write = 1; debug_address = 6'd7; debug_write_value = 32'hDEADBEEF;
      settle(); chk("wr_c0_we", rf_write_enable, 0);
      cyc();
      settle();
      chk("wr_c1_we", rf_write_enable, 1); chk("wr_c1_wa", rf_write_address, 7);
      chk("wr_c1_wv", rf_write_value, 32'hDEADBEEF); chk("wr_c1_ack", debug_ack, 0);
      cyc();
      settle(); chk("wr_c2_ack", debug_ack, 1); chk("wr_rdval_kept", debug_read_value, last_read);
      ref_mem[7] = 32'hDEADBEEF;
      debug_request = 0;
      cyc();
      do_read(6'd7, 1'b0, '0);
      chk("wr_readback", last_read, 32'hDEADBEEF);

      // Plain read and bypass read of addr 9
      proc_write_enable = 1; proc_write_address = 6'd9; proc_write_value = 32'hA5A5A5A5;
      cyc();
      proc_write_enable = 0;
      do_read(6'd9, 1'b0, '0);
      chk("rd_plain", last_read, 32'hA5A5A5A5);
      do_read(6'd9, 1'b1, 32'h11);
      chk("rd_bypass", last_read, 32'h11);

      // Starvation: processor writes every cycle until stalled, then drains one more
      debug_request = 1; debug_write = 1; debug_address = 6'd40; debug_write_value = 32'hCAFE0040;
      proc_write_enable = 1;
      for (int c = 0; c <= LIMIT + 1; c++) begin
         proc_write_address = AW'($urandom_range(0, 31)); proc_write_value = $urandom;
         settle();
         chk($sformatf("sv_c%0d_stall", c), stall, (c == LIMIT + 1));
         chk($sformatf("sv_c%0d_wa", c), rf_write_address, proc_write_address);
         chk($sformatf("sv_c%0d_ack", c), debug_ack, 0);
         cyc();
      end
      proc_write_enable = 0;
      settle();
      chk("sv_issue_stall", stall, 1); chk("sv_issue_we", rf_write_enable, 1);
      chk("sv_issue_wa", rf_write_address, 40); chk("sv_issue_wv", rf_write_value, 32'hCAFE0040);
      cyc();
      settle(); chk("sv_ack", debug_ack, 1); chk("sv_ack_stall", stall, 0);
      ref_mem[40] = 32'hCAFE0040;
      debug_request = 0;
      cyc();

      // Reset during READ_ACCESS
      debug_request = 1; debug_write = 0; debug_address = 6'd20;
      cyc(); cyc();
      settle(); chk("rr_pre_stall", stall, 1);
      reset = 1; #1;
      chk("rr_stall", stall, 0); chk("rr_ack", debug_ack, 0); chk("rr_rdval", debug_read_value, 0);
      last_read = '0;
      debug_request = 0;
      cyc();
      reset = 0;
      for (int c = 0; c < 4; c++) begin
         settle(); chk("rr_no_ack", debug_ack, 0); chk("rr_idle_stall", stall, 0);
         cyc();
      end
      do_read(6'd20, 1'b0, '0);

      // Reset during WRITE_WAIT: the debug write must never land
      debug_request = 1; debug_write = 1; debug_address = 6'd50; debug_write_value = ~ref_mem[50];
      proc_write_enable = 1; proc_write_address = 6'd1; proc_write_value = $urandom;
      cyc();
      settle();
      reset = 1; #1;
      proc_write_enable = 0; debug_request = 0;
      cyc();
      reset = 0;
      cyc(); cyc();
      settle(); chk("rw_not_issued", mem[50], ref_mem[50]);
      cyc();

      // Randomized accesses against the reference memory
      for (int op = 0; op < 40; op++) begin
         logic          is_wr;
         logic [AW-1:0] a;
         logic [DW-1:0] v;
         int            exp_ack;
         bit            done;
         is_wr = 1'($urandom_range(0, 1));
         a = is_wr ? AW'($urandom_range(32, 63)) : AW'($urandom_range(0, 63));
         v = $urandom;
         exp_ack = is_wr ? -1 : 3;
         done = 0;
         debug_request = 1; debug_write = is_wr; debug_address = a; debug_write_value = v;
         for (int k = 0; k < 20 && !done; k++) begin
            if (k > 0) begin
               debug_address = AW'($urandom); debug_write_value = $urandom;
               debug_write = 1'($urandom);
            end
            proc_read_address_1 = AW'($urandom); proc_read_address_2 = AW'($urandom);
            proc_write_address = AW'($urandom_range(0, 31)); proc_write_value = $urandom;
            proc_write_enable = stall ? 1'b0 : 1'($urandom_range(0, 1));
            settle();
            if (is_wr && k >= 1 && exp_ack < 0 && !proc_write_enable) begin
               exp_ack = k + 1;
               chk("rnd_wr_issue", {rf_write_enable, rf_write_address, rf_write_value}, {1'b1, a, v});
            end
            if (debug_ack) begin
               chk("rnd_ack_cycle", k, exp_ack);
               if (is_wr) begin
                  ref_mem[a] = v;
                  chk("rnd_rdval_kept", debug_read_value, last_read);
               end else begin
                  chk("rnd_rdval", debug_read_value, ref_mem[a]);
                  last_read = ref_mem[a];
               end
               debug_request = 0;
               done = 1;
            end
            cyc();
         end
         if (!done) chk("rnd_ack_timeout", 0, 1);
      end
      proc_write_enable = 0;
      cyc();

      for (int i = 0; i < 64; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
